// File: rtl/conv_weight_fetcher_if.sv
// Bundle between the weight fetcher, the weight ROM and the conv engine:
// run control, ROM read port and the weight stream.
interface conv_weight_fetcher_if #(
    parameter int CONV_CHANNEL = 4,
    parameter int KERNEL_SIZE  = 25,
    parameter int DATA_WIDTH   = 8
);
    localparam int ADDR_WIDTH = $clog2(KERNEL_SIZE);
    localparam int WORD_WIDTH = DATA_WIDTH * CONV_CHANNEL;

    logic                  start;
    logic                  abort;
    logic                  busy;
    logic                  done;
    logic                  rom_en;
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [WORD_WIDTH-1:0] rom_data;
    logic                  w_valid;
    logic                  w_ready;
    logic [WORD_WIDTH-1:0] w_data;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic                  w_last;

    modport master (
        input  start, abort, rom_data, w_ready,
        output busy, done, rom_en, rom_addr, w_valid, w_data, w_idx, w_last
    );

    modport slave (
        output start, abort, rom_data, w_ready,
        input  busy, done, rom_en, rom_addr, w_valid, w_data, w_idx, w_last
    );
endinterface

// File: rtl/conv_weight_fetcher.sv
// Walks the weight ROM once per run and streams each packed word to the conv
// engine, hiding the ROM's one-cycle read latency behind a 2-entry buffer.
module conv_weight_fetcher #(
    parameter int CONV_CHANNEL = 4,
    parameter int KERNEL_SIZE  = 25,
    parameter int DATA_WIDTH   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    conv_weight_fetcher_if.master bus
);
    localparam int ADDR_WIDTH = $clog2(KERNEL_SIZE);
    localparam int CNT_WIDTH  = $clog2(KERNEL_SIZE + 1);
    localparam logic [CNT_WIDTH-1:0]  KSIZE    = CNT_WIDTH'(KERNEL_SIZE);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(KERNEL_SIZE - 1);

    typedef enum logic {IDLE, RUN} state_t;

    typedef struct packed {
        logic                                   last;
        logic [ADDR_WIDTH-1:0]                  idx;
        logic [CONV_CHANNEL-1:0][DATA_WIDTH-1:0] data;
    } entry_t;

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  issue_cnt_q, issue_cnt_d;
    logic                  inflight_q, inflight_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [1:0]            count_q, count_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic                  wr_ptr_q, wr_ptr_d;
    entry_t [1:0]          buf_q, buf_d;
    logic                  done_q, done_d;

    logic   run, pop, push, issue;
    logic [1:0] occ;
    entry_t head;

    assign run  = (state_q == RUN);
    assign head = buf_q[rd_ptr_q];
    assign pop  = (count_q != 2'd0) && bus.w_ready;
    assign push = inflight_q;
    assign occ  = count_q + 2'(inflight_q);

    // A slot freed by this cycle's pop may be refilled by a read issued now,
    // which keeps one word per cycle flowing with a 2-deep buffer.
    assign issue = run && (issue_cnt_q < KSIZE) &&
                   ((occ < 2'd2) || ((occ == 2'd2) && pop));

    always_comb begin
        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        inflight_d  = 1'b0;
        addr_d      = addr_q;
        count_d     = count_q + 2'(push) - 2'(pop);
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        buf_d       = buf_q;
        done_d      = 1'b0;

        if (issue) begin
            issue_cnt_d = issue_cnt_q + CNT_WIDTH'(1);
            addr_d      = issue_cnt_q[ADDR_WIDTH-1:0];
            inflight_d  = 1'b1;
        end

        // addr_q still holds the address of the read now returning
        if (push) begin
            buf_d[wr_ptr_q].data = bus.rom_data;
            buf_d[wr_ptr_q].idx  = addr_q;
            buf_d[wr_ptr_q].last = (addr_q == LAST_IDX);
            wr_ptr_d             = ~wr_ptr_q;
        end

        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d     = RUN;
                    issue_cnt_d = '0;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_d    = IDLE;
                    inflight_d = 1'b0;
                    count_d    = 2'd0;
                    rd_ptr_d   = 1'b0;
                    wr_ptr_d   = 1'b0;
                end else if (pop && head.last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            issue_cnt_q <= '0;
            inflight_q  <= 1'b0;
            addr_q      <= '0;
            count_q     <= 2'd0;
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
            buf_q       <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            inflight_q  <= inflight_d;
            addr_q      <= addr_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            buf_q       <= buf_d;
            done_q      <= done_d;
        end
    end

    assign bus.busy     = run;
    assign bus.done     = done_q;
    assign bus.rom_en   = issue;
    assign bus.rom_addr = issue ? issue_cnt_q[ADDR_WIDTH-1:0] : addr_q;
    assign bus.w_valid  = (count_q != 2'd0);
    assign bus.w_data   = head.data;
    assign bus.w_idx    = head.idx;
    assign bus.w_last   = head.last;
endmodule
